// File: rtl/pll_ctrl_if.sv
// Configuration handshake into the PLL controller.
// Requester drives valid and dividers; controller drives ready.
interface pll_ctrl_if #(
    parameter int REF_DIV_WIDTH = 8,
    parameter int FB_DIV_WIDTH  = 12
);
    logic                     cfg_valid_i;
    logic                     cfg_ready_o;
    logic [REF_DIV_WIDTH-1:0] ref_div_i;
    logic [FB_DIV_WIDTH-1:0]  fb_div_i;

    modport master (
        output cfg_valid_i,
        output ref_div_i,
        output fb_div_i,
        input  cfg_ready_o
    );

    modport slave (
        input  cfg_valid_i,
        input  ref_div_i,
        input  fb_div_i,
        output cfg_ready_o
    );
endinterface

// File: rtl/pll_ctrl.sv
// PLL bring-up controller: applies dividers, pulses PLL reset,
// qualifies lock and reports status.
module pll_ctrl #(
    parameter int REF_DIV_WIDTH  = 8,
    parameter int FB_DIV_WIDTH   = 12,
    parameter int RST_CYCLES     = 16,
    parameter int STABLE_CYCLES  = 32,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                     clk_i,
    input  logic                     arst_i,
    pll_ctrl_if.slave                cfg,
    output logic                     pll_arst_no,
    output logic [REF_DIV_WIDTH-1:0] pll_ref_div_o,
    output logic [FB_DIV_WIDTH-1:0]  pll_fb_div_o,
    input  logic                     pll_locked_i,
    output logic                     locked_o,
    output logic                     status_valid_o,
    output logic [1:0]               status_code_o
);

    localparam int RW = $clog2(RST_CYCLES) + 1;
    localparam int SW = $clog2(STABLE_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
    localparam logic [SW-1:0] STB_LIM  = SW'(STABLE_CYCLES);
    localparam logic [TW-1:0] TO_LIM   = TW'(TIMEOUT_CYCLES);

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_INVALID = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;
    localparam logic [1:0] ST_LOST    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RESET,
        S_WAIT_LOCK,
        S_LOCKED
    } state_t;

    state_t        state;
    logic          ready_q;
    logic          lock_meta;
    logic          lock_sync;
    logic [RW-1:0] rst_cnt;
    logic [SW-1:0] stb_cnt;
    logic [TW-1:0] to_cnt;
    logic [SW-1:0] stb_nxt;
    logic [TW-1:0] to_nxt;
    logic          xfer;
    logic          div_ok;

    assign cfg.cfg_ready_o = ready_q;
    assign xfer   = cfg.cfg_valid_i & ready_q;
    assign div_ok = (|cfg.ref_div_i) & (|cfg.fb_div_i);

    // Lock input is asynchronous to clk_i
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_meta <= pll_locked_i;
            lock_sync <= lock_meta;
        end
    end

    always_comb begin
        stb_nxt = '0;
        if (lock_sync) begin
            stb_nxt = (stb_cnt == STB_LIM) ? stb_cnt : stb_cnt + SW'(1);
        end
        to_nxt = (to_cnt == TO_LIM) ? to_cnt : to_cnt + TW'(1);
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state          <= S_IDLE;
            ready_q        <= 1'b1;
            pll_arst_no    <= 1'b0;
            pll_ref_div_o  <= '0;
            pll_fb_div_o   <= '0;
            locked_o       <= 1'b0;
            status_valid_o <= 1'b0;
            status_code_o  <= ST_OK;
            rst_cnt        <= '0;
            stb_cnt        <= '0;
            to_cnt         <= '0;
        end else begin
            status_valid_o <= 1'b0;
            status_code_o  <= ST_OK;
            unique case (state)
                S_IDLE, S_LOCKED: begin
                    // A good config outranks a coincident lock loss
                    if (xfer && div_ok) begin
                        pll_ref_div_o <= cfg.ref_div_i;
                        pll_fb_div_o  <= cfg.fb_div_i;
                        locked_o      <= 1'b0;
                        pll_arst_no   <= 1'b0;
                        ready_q       <= 1'b0;
                        rst_cnt       <= '0;
                        state         <= S_RESET;
                    end else if (xfer) begin
                        status_valid_o <= 1'b1;
                        status_code_o  <= ST_INVALID;
                    end else if (state == S_LOCKED && !lock_sync) begin
                        status_valid_o <= 1'b1;
                        status_code_o  <= ST_LOST;
                        locked_o       <= 1'b0;
                        pll_arst_no    <= 1'b0;
                        ready_q        <= 1'b0;
                        rst_cnt        <= '0;
                        state          <= S_RESET;
                    end
                end
                S_RESET: begin
                    if (rst_cnt == RST_LAST) begin
                        pll_arst_no <= 1'b1;
                        stb_cnt     <= '0;
                        to_cnt      <= '0;
                        state       <= S_WAIT_LOCK;
                    end else begin
                        rst_cnt <= rst_cnt + RW'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    stb_cnt <= stb_nxt;
                    to_cnt  <= to_nxt;
                    // Lock is checked first so it wins a tie with timeout
                    if (stb_nxt == STB_LIM) begin
                        locked_o       <= 1'b1;
                        ready_q        <= 1'b1;
                        status_valid_o <= 1'b1;
                        status_code_o  <= ST_OK;
                        state          <= S_LOCKED;
                    end else if (to_nxt == TO_LIM) begin
                        pll_arst_no    <= 1'b0;
                        ready_q        <= 1'b1;
                        status_valid_o <= 1'b1;
                        status_code_o  <= ST_TIMEOUT;
                        state          <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_ctrl.sv
// Bench for pll_ctrl: cycle model compared every cycle,
// plus directed scenarios with hand-computed latencies.
module tb_pll_ctrl;

    localparam int RW   = 8;
    localparam int FW   = 12;
    localparam int RSTC = 16;
    localparam int STBC = 32;
    localparam int TOC  = 100;

    localparam int M_IDLE   = 0;
    localparam int M_RESET  = 1;
    localparam int M_WAIT   = 2;
    localparam int M_LOCKED = 3;

    logic          clk        = 1'b0;
    logic          arst       = 1'b1;
    logic          pll_locked = 1'b0;
    logic          pll_arst_n;
    logic [RW-1:0] pll_ref;
    logic [FW-1:0] pll_fb;
    logic          locked;
    logic          sv;
    logic [1:0]    code;

    int n_cmp = 0;
    int n_bad = 0;

    pll_ctrl_if #(.REF_DIV_WIDTH(RW), .FB_DIV_WIDTH(FW)) cfg ();

    pll_ctrl #(
        .REF_DIV_WIDTH (RW),
        .FB_DIV_WIDTH  (FW),
        .RST_CYCLES    (RSTC),
        .STABLE_CYCLES (STBC),
        .TIMEOUT_CYCLES(TOC)
    ) dut (
        .clk_i         (clk),
        .arst_i        (arst),
        .cfg           (cfg),
        .pll_arst_no   (pll_arst_n),
        .pll_ref_div_o (pll_ref),
        .pll_fb_div_o  (pll_fb),
        .pll_locked_i  (pll_locked),
        .locked_o      (locked),
        .status_valid_o(sv),
        .status_code_o (code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: mode, cycles spent in mode, run of synced-high lock
    int            m_mode = M_IDLE;
    int            m_t    = 0;
    int            m_run  = 0;
    logic [RW-1:0] e_ref  = '0;
    logic [FW-1:0] e_fb   = '0;
    logic          e_sv   = 1'b0;
    logic [1:0]    e_code = 2'd0;
    logic          p_arst = 1'b1;
    logic          p_v    = 1'b0;
    logic          p_lk   = 1'b0;
    logic [RW-1:0] p_r    = '0;
    logic [FW-1:0] p_f    = '0;
    logic          syn;
    logic [25:0]   exp_v;
    logic [25:0]   act_v;
    bit            lkq[$];

    initial begin : model
        lkq.push_back(1'b0);
        lkq.push_back(1'b0);
        forever begin
            @(negedge clk);
            e_sv   = 1'b0;
            e_code = 2'd0;
            if (arst) begin
                m_mode = M_IDLE;
                m_t    = 0;
                m_run  = 0;
                e_ref  = '0;
                e_fb   = '0;
                lkq.delete();
                lkq.push_back(1'b0);
                lkq.push_back(1'b0);
            end else if (!p_arst) begin
                syn = lkq.pop_front();
                lkq.push_back(p_lk);
                if ((m_mode == M_IDLE || m_mode == M_LOCKED) && p_v) begin
                    if (p_r != 0 && p_f != 0) begin
                        e_ref  = p_r;
                        e_fb   = p_f;
                        m_mode = M_RESET;
                        m_t    = 0;
                    end else begin
                        e_sv   = 1'b1;
                        e_code = 2'd1;
                    end
                end else if (m_mode == M_LOCKED && !syn) begin
                    e_sv   = 1'b1;
                    e_code = 2'd3;
                    m_mode = M_RESET;
                    m_t    = 0;
                end else if (m_mode == M_RESET) begin
                    m_t++;
                    if (m_t == RSTC) begin
                        m_mode = M_WAIT;
                        m_t    = 0;
                        m_run  = 0;
                    end
                end else if (m_mode == M_WAIT) begin
                    m_t++;
                    m_run = syn ? m_run + 1 : 0;
                    if (m_run >= STBC) begin
                        m_mode = M_LOCKED;
                        e_sv   = 1'b1;
                        e_code = 2'd0;
                    end else if (m_t >= TOC) begin
                        m_mode = M_IDLE;
                        e_sv   = 1'b1;
                        e_code = 2'd2;
                    end
                end
            end
            exp_v = {(m_mode == M_WAIT || m_mode == M_LOCKED),
                     (m_mode == M_IDLE || m_mode == M_LOCKED),
                     (m_mode == M_LOCKED), e_sv, e_code, e_ref, e_fb};
            act_v = {pll_arst_n, cfg.cfg_ready_o, locked, sv, code,
                     pll_ref, pll_fb};
            chk("outputs", {6'd0, act_v}, {6'd0, exp_v});
            p_arst = arst;
            p_v    = cfg.cfg_valid_i;
            p_r    = cfg.ref_div_i;
            p_f    = cfg.fb_div_i;
            p_lk   = pll_locked;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [RW-1:0] r, input logic [FW-1:0] f);
        cfg.cfg_valid_i = 1'b1;
        cfg.ref_div_i   = r;
        cfg.fb_div_i    = f;
        tick();
        cfg.cfg_valid_i = 1'b0;
    endtask

    task automatic count_low(output int n);
        n = 0;
        while (pll_arst_n !== 1'b1 && n < 200) begin
            n++;
            tick();
        end
    endtask

    task automatic wait_pulse(output int n);
        n = 0;
        while (sv !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin : stim
        int n;
        cfg.cfg_valid_i = 1'b0;
        cfg.ref_div_i   = '0;
        cfg.fb_div_i    = '0;
        repeat (3) tick();
        chk("rst_arst_n", {31'd0, pll_arst_n}, 32'd0);
        chk("rst_div", {12'd0, pll_ref, pll_fb}, 32'd0);
        chk("rst_status", {28'd0, locked, sv, code}, 32'd0);
        arst = 1'b0;
        tick();
        chk("ready_after_rst", {31'd0, cfg.cfg_ready_o}, 32'd1);

        // Basic bring-up, lock 50 cycles after reset release
        send(8'd1, 12'd10);
        chk("cfg_div", {12'd0, pll_ref, pll_fb}, {12'd0, 8'd1, 12'd10});
        count_low(n);
        chk("reset_len", n, 16);
        repeat (50) tick();
        pll_locked = 1'b1;
        wait_pulse(n);
        chk("lock_latency", n, 34);
        chk("ok_code", {29'd0, locked, code}, {29'd0, 1'b1, 2'd0});
        tick();
        chk("pulse_single", {31'd0, sv}, 32'd0);

        // Zero divider while locked
        send(8'd0, 12'd5);
        chk("invalid_pulse", {29'd0, sv, code}, {29'd0, 1'b1, 2'd1});
        chk("invalid_keep", {10'd0, pll_arst_n, locked, pll_ref, pll_fb},
            {10'd0, 1'b1, 1'b1, 8'd1, 12'd10});

        // Three-cycle lock drop
        pll_locked = 1'b0;
        repeat (3) tick();
        pll_locked = 1'b1;
        chk("lost_pulse", {27'd0, sv, code, pll_arst_n, locked},
            {27'd0, 1'b1, 2'd3, 1'b0, 1'b0});
        count_low(n);
        chk("relock_reset", n, 16);
        wait_pulse(n);
        chk("relock_time", n, 32);
        chk("relock_ok", {9'd0, locked, code, pll_ref, pll_fb},
            {9'd0, 1'b1, 2'd0, 8'd1, 12'd10});

        // New config on the same edge as lock loss, then timeout
        pll_locked = 1'b0;
        tick();
        tick();
        send(8'd3, 12'd20);
        chk("cfg_beats_loss", {28'd0, sv, code, pll_arst_n}, 32'd0);
        chk("cfg_beats_loss_div", {12'd0, pll_ref, pll_fb},
            {12'd0, 8'd3, 12'd20});
        count_low(n);
        chk("reset_len2", n, 16);
        wait_pulse(n);
        chk("timeout_time", n, 100);
        chk("timeout_state", {27'd0, code, pll_arst_n, cfg.cfg_ready_o, locked},
            {27'd0, 2'd2, 1'b0, 1'b1, 1'b0});

        // Zero divider while idle
        send(8'd5, 12'd0);
        chk("invalid_idle", {29'd0, sv, code}, {29'd0, 1'b1, 2'd1});
        chk("invalid_idle_keep",
            {10'd0, pll_arst_n, cfg.cfg_ready_o, pll_ref, pll_fb},
            {10'd0, 1'b0, 1'b1, 8'd3, 12'd20});

        // Lock glitch during qualification
        send(8'd2, 12'd7);
        count_low(n);
        repeat (5) tick();
        pll_locked = 1'b1;
        repeat (10) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        wait_pulse(n);
        chk("glitch_relock", n, 34);
        chk("glitch_ok", {29'd0, locked, code}, {29'd0, 1'b1, 2'd0});

        // Qualification and timeout finishing together
        pll_locked = 1'b0;
        send(8'd4, 12'd9);
        count_low(n);
        repeat (66) tick();
        pll_locked = 1'b1;
        wait_pulse(n);
        chk("tie_latency", n, 34);
        chk("tie_lock_wins", {29'd0, locked, code}, {29'd0, 1'b1, 2'd0});

        // Async reset in the middle of WAIT_LOCK
        pll_locked = 1'b0;
        send(8'd6, 12'd11);
        count_low(n);
        repeat (10) tick();
        pll_locked = 1'b1;
        repeat (5) tick();
        arst = 1'b1;
        #1;
        chk("arst_abort",
            {6'd0, pll_arst_n, locked, sv, code, pll_ref, pll_fb}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("arst_no_pulse", {31'd0, sv}, 32'd0);
        end
        arst = 1'b0;
        tick();
        chk("ready_after_abort", {30'd0, cfg.cfg_ready_o, pll_arst_n},
            {30'd0, 1'b1, 1'b0});

        send(8'd1, 12'd10);
        count_low(n);
        chk("reset_len3", n, 16);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pll_ctrl.md
PLL_CTRL -- requirements
Module: pll_ctrl

Interface
REQ-001 The block SHALL have parameter REF_DIV_WIDTH, default 8, width of the reference divider.
REQ-002 The block SHALL have parameter FB_DIV_WIDTH, default 12, width of the feedback divider.
REQ-003 The block SHALL have parameter RST_CYCLES, default 16, number of cycles PLL reset is held.
REQ-004 The block SHALL have parameter STABLE_CYCLES, default 32, consecutive synchronized-lock cycles required to declare lock.
REQ-005 The block SHALL have parameter TIMEOUT_CYCLES, default 65535, maximum cycles spent waiting for lock.
REQ-006 The block SHALL have one clock and an asynchronous active-high reset; ports are clk_i and arst_i.
REQ-007 clk_i  in  1  block clock; all logic on its rising edge.
REQ-008 arst_i  in  1  asynchronous active-high reset.
REQ-009 cfg_valid_i  in  1  configuration request valid.
REQ-010 cfg_ready_o  out  1  controller can accept a configuration.
REQ-011 ref_div_i  in  REF_DIV_WIDTH  requested reference divider.
REQ-012 fb_div_i  in  FB_DIV_WIDTH  requested feedback divider.
REQ-013 pll_arst_no  out  1  active-low reset to the PLL.
REQ-014 pll_ref_div_o  out  REF_DIV_WIDTH  registered divider driven to the PLL.
REQ-015 pll_fb_div_o  out  FB_DIV_WIDTH  registered divider driven to the PLL.
REQ-016 pll_locked_i  in  1  asynchronous PLL lock indication.
REQ-017 locked_o  out  1  qualified lock; high only in LOCKED.
REQ-018 status_valid_o  out  1  one-cycle status pulse.
REQ-019 status_code_o  out  2  0=OK, 1=INVALID, 2=TIMEOUT, 3=LOST_LOCK; valid with status_valid_o.

Function
REQ-020 pll_locked_i SHALL pass through a 2-flop synchronizer; all lock decisions use the synchronized value (2-cycle latency).
REQ-021 States SHALL be IDLE, RESET, WAIT_LOCK, LOCKED.
REQ-022 cfg_ready_o SHALL be high in IDLE and LOCKED only; a transfer occurs when cfg_valid_i and cfg_ready_o are both high on a rising edge.
REQ-023 On a transfer with ref_div_i==0 or fb_div_i==0, the block SHALL pulse status_code_o=1 the next cycle, keep the current state and dividers, and leave the PLL untouched.
REQ-024 On a valid transfer, the block SHALL register both dividers into pll_*_div_o, clear locked_o, and enter RESET the next cycle.
REQ-025 In RESET, pll_arst_no SHALL be low for exactly RST_CYCLES cycles, then the block SHALL enter WAIT_LOCK with pll_arst_no high.
REQ-026 In WAIT_LOCK, a stable counter SHALL increment while synchronized lock is high and clear to 0 when it is low; on reaching STABLE_CYCLES the block SHALL enter LOCKED and pulse status_code_o=0.
REQ-027 In WAIT_LOCK, a timeout counter SHALL start from 0 on entry; on reaching TIMEOUT_CYCLES without lock, the block SHALL pulse status_code_o=2, drive pll_arst_no low and enter IDLE.
REQ-028 If stable qualification and timeout complete in the same cycle, lock SHALL win.
REQ-029 In LOCKED, a synchronized lock low for one cycle SHALL pulse status_code_o=3, drop locked_o, and enter RESET to re-lock automatically with the same dividers.
REQ-030 In LOCKED, a valid cfg transfer SHALL take priority over a simultaneous lock loss: only the new configuration is applied and no LOST_LOCK is reported.
REQ-031 Dividers SHALL change only on a valid transfer; cfg inputs SHALL be ignored outside IDLE and LOCKED.
REQ-032 status_valid_o SHALL never be high for two consecutive cycles from the same event.
REQ-033 Counters SHALL be sized $clog2 of their limit plus 1 and SHALL saturate, never wrap.

Reset
REQ-034 While arst_i is high: state IDLE, pll_arst_no=0, pll_ref_div_o=0, pll_fb_div_o=0, locked_o=0, status_valid_o=0, status_code_o=0, cfg_ready_o=1 after release, synchronizer and counters cleared.
REQ-035 Assertion of arst_i in any state, including mid-RESET or mid-WAIT_LOCK, SHALL abort immediately with no status pulse.

Verification
REQ-036 Send ref=1, fb=10, and pll_locked_i rises 50 cycles after pll_arst_no rises -> pll_arst_no low for 16 cycles; locked_o and OK pulse occur 2+32 cycles after the lock rise; dividers read 1/10.
REQ-037 Send ref=0, fb=5 -> INVALID pulse the next cycle; state, dividers and pll_arst_no are unchanged.
REQ-038 Use TIMEOUT_CYCLES=100 and never assert lock -> TIMEOUT pulse 100 cycles after WAIT_LOCK entry; pll_arst_no=0; IDLE.
REQ-039 When LOCKED, drop pll_locked_i for 3 cycles -> LOST_LOCK pulse, a 16-cycle reset, then re-lock with an OK pulse.
REQ-040 Lock glitch (high 10 cycles, low 1, high) during WAIT_LOCK -> stable count restarts; OK only after 32 uninterrupted cycles.
REQ-041 Assert arst_i mid-WAIT_LOCK -> all outputs return to reset values at once with no status pulse.
